// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory controller.
// Lane alignment is little-endian: byte lane = addr[1:0], half lane = addr[1].
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_RSV = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RESP,
    ST_RMW_RD,
    ST_RMW_MRG,
    ST_RMW_WR,
    ST_ERR
  } state_e;

  // Offsets arrive normalised (half: off[0]=0, word: off=0), so a plain shift picks the lane.
  function automatic logic [WORD_W-1:0] load_extract(input logic [WORD_W-1:0] word,
                                                     input logic [1:0] off,
                                                     input size_e size,
                                                     input logic uns);
    logic [WORD_W-1:0] sh;
    logic [WORD_W-1:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B:    res = {{24{~uns & sh[7]}}, sh[7:0]};
      SZ_H:    res = {{16{~uns & sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [WORD_W-1:0] store_merge(input logic [WORD_W-1:0] old,
                                                    input logic [WORD_W-1:0] nw,
                                                    input logic [1:0] off,
                                                    input size_e size);
    logic [WORD_W-1:0] res;
    res = old;
    case (size)
      SZ_B:    res[{off, 3'b000} +: 8] = nw[7:0];
      SZ_H:    res[{off[1], 4'b0000} +: 16] = nw[15:0];
      default: res = nw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane datapath: load extraction/extension and sub-word store merge.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] rd_word,
  input  logic [WORD_W-1:0] st_data,
  input  logic [1:0]        off,
  input  size_e             size,
  input  logic              uns,
  output logic [WORD_W-1:0] ld_data,
  output logic [WORD_W-1:0] mrg_data
);

  assign ld_data  = load_extract(rd_word, off, size, uns);
  assign mrg_data = store_merge(rd_word, st_data, off, size);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: MEM-stage handshake to a synchronous RAM with sub-word RMW.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned/reserved accesses respond with rsp_err.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  output logic              rsp_load,
  output logic [DATA_W-1:0] rsp_data,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data
);

  state_e              state_reg, state_next;
  size_e               size_reg;
  logic                uns_reg;
  logic [1:0]          off_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   merged_reg;
  logic [4:0]          rd_reg;

  size_e               req_sz;
  size_e               sz_norm;
  logic [1:0]          off_norm;
  logic                trap;
  logic                accept;
  logic [DATA_W-1:0]   ld_data;
  logic [DATA_W-1:0]   mrg_data;
  logic                unused_addr_hi;

  // High address bits are dropped so accesses wrap inside the RAM.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign req_sz = size_e'(req_size);
  assign accept = (state_reg == ST_IDLE) && req_valid;

  always_comb begin
    sz_norm  = req_sz;
    off_norm = req_addr[1:0];
    case (req_sz)
      SZ_H:         off_norm = {req_addr[1], 1'b0};
      SZ_W, SZ_RSV: begin
        sz_norm  = SZ_W;
        off_norm = 2'b00;
      end
      default: ;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = (req_sz == SZ_H && req_addr[0]) ||
                (req_sz == SZ_W && req_addr[1:0] != 2'b00) ||
                (req_sz == SZ_RSV);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      size_reg   <= SZ_B;
      uns_reg    <= 1'b0;
      off_reg    <= 2'b00;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rd_reg     <= '0;
      merged_reg <= '0;
    end else begin
      if (accept) begin
        size_reg  <= sz_norm;
        uns_reg   <= req_unsigned;
        off_reg   <= off_norm;
        addr_reg  <= req_addr[ADDR_W+1:2];
        wdata_reg <= req_wdata;
        rd_reg    <= req_rd;
      end
      if (state_reg == ST_RMW_MRG) merged_reg <= mrg_data;
    end
  end

  dmem_lane_align u_align (
    .rd_word  (rd_data),
    .st_data  (wdata_reg),
    .off      (off_reg),
    .size     (size_reg),
    .uns      (uns_reg),
    .ld_data  (ld_data),
    .mrg_data (mrg_data)
  );

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_load   = 1'b0;
    rsp_data   = '0;
    rsp_rd     = '0;
    rsp_err    = 1'b0;
    wr         = 1'b0;
    rd         = 1'b0;
    addr       = '0;
    wr_data    = '0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = reset;
        if (req_valid) begin
          if (trap)                state_next = ST_ERR;
          else if (!req_we)        state_next = ST_RD;
          else if (sz_norm == SZ_W) state_next = ST_WR;
          else                     state_next = ST_RMW_RD;
        end
      end
      ST_WR: begin
        wr         = 1'b1;
        addr       = addr_reg;
        wr_data    = wdata_reg;
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_RD: begin
        rd         = 1'b1;
        addr       = addr_reg;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_load   = 1'b1;
        rsp_data   = ld_data;
        rsp_rd     = rd_reg;
        state_next = ST_IDLE;
      end
      ST_RMW_RD: begin
        rd         = 1'b1;
        addr       = addr_reg;
        state_next = ST_RMW_MRG;
      end
      ST_RMW_MRG: state_next = ST_RMW_WR;
      ST_RMW_WR: begin
        wr         = 1'b1;
        addr       = addr_reg;
        wr_data    = merged_reg;
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        rsp_valid  = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        rsp_err    = 1'b1;
`endif
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed, table-driven bench for dmem_ctrl with a small synchronous RAM model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        rsp_valid, rsp_load, rsp_err, wr, rd;
  logic [31:0] rsp_data, wr_data;
  logic [4:0]  rsp_rd;
  logic [8:0]  addr;
  logic [31:0] rd_data = '0;
  logic [31:0] mem [512];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_load(rsp_load), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data)
  );

  always @(posedge clk) begin
    if (wr) mem[addr] <= wr_data;
    if (rd) rd_data <= mem[addr];
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [4:0]  rdn;
    int          lat;
    logic [8:0]  ea;
    logic [31:0] ed;
    logic        err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rdn,
                              input int lat, input logic [8:0] ea, input logic [31:0] ed,
                              input logic err);
    vec_t v;
    v = '{we, sz, uns, a, wd, rdn, lat, ea, ed, err};
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input int idx);
    int cyc, nrd, nwr, nboth, lat_got;
    logic got, ld_got, err_got;
    logic [4:0]  rd_got;
    logic [8:0]  a_got;
    logic [31:0] wd_got, rsp_got;
    nrd = 0; nwr = 0; nboth = 0; lat_got = -1; got = 1'b0; cyc = 0;
    ld_got = 1'b0; err_got = 1'b0; rd_got = '0; a_got = '0; wd_got = '0; rsp_got = '0;
    @(negedge clk);
    chk($sformatf("v%0d idle_rsp_valid", idx), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("v%0d ready", idx), {31'd0, req_ready}, 32'd1);
    req_we = v.we; req_size = v.sz; req_unsigned = v.uns;
    req_addr = v.a; req_wdata = v.wd; req_rd = v.rdn; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (!got && cyc < 6) begin
      @(negedge clk);
      cyc++;
      if (rd && wr) nboth++;
      if (rd) begin nrd++; a_got = addr; end
      if (wr) begin nwr++; a_got = addr; wd_got = wr_data; end
      if (rsp_valid) begin
        got = 1'b1; lat_got = cyc; ld_got = rsp_load; err_got = rsp_err;
        rd_got = rsp_rd; rsp_got = rsp_data;
      end
    end
    chk($sformatf("v%0d latency", idx), lat_got, v.lat);
    chk($sformatf("v%0d rsp_err", idx), {31'd0, err_got}, {31'd0, v.err});
    chk($sformatf("v%0d rsp_load", idx), {31'd0, ld_got}, {31'd0, ~v.we & ~v.err});
    chk($sformatf("v%0d rsp_rd", idx), {27'd0, rd_got}, (v.we || v.err) ? 32'd0 : {27'd0, v.rdn});
    chk($sformatf("v%0d rd_count", idx), nrd, (v.lat >= 2 && !v.err) ? 1 : 0);
    chk($sformatf("v%0d wr_count", idx), nwr, (v.we && !v.err) ? 1 : 0);
    chk($sformatf("v%0d rd_wr_overlap", idx), nboth, 0);
    if (!v.err) chk($sformatf("v%0d ram_addr", idx), {23'd0, a_got}, {23'd0, v.ea});
    if (v.we) begin
      if (!v.err) chk($sformatf("v%0d wr_data", idx), wd_got, v.ed);
      chk($sformatf("v%0d store_rsp_data", idx), rsp_got, 32'd0);
    end else begin
      chk($sformatf("v%0d rsp_data", idx), rsp_got, v.ed);
    end
    $display("txn %0d we=%0d size=%0d addr=%h lat=%0d ram_addr=%h data=%h err=%0d",
             idx, v.we, v.sz, v.a, lat_got, a_got, v.we ? wd_got : rsp_got, err_got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2, nrsp;
    logic [31:0] d1, d2;
    logic [4:0]  rd1, rd2;
    logic [2:0]  rdy;
    vec_t v;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset strobes", {30'd0, rd, wr}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("post_reset req_ready", {31'd0, req_ready}, 32'd1);

    // we, size, uns, addr, wdata, rd, latency, ram addr, expected data, err
    vt.push_back(mk(1, 2, 0, 32'h14, 32'hDEADBEEF, 0, 1, 9'd5, 32'hDEADBEEF, 0));
    vt.push_back(mk(1, 2, 0, 32'h14, 32'h8899AABB, 0, 1, 9'd5, 32'h8899AABB, 0));
    vt.push_back(mk(1, 2, 0, 32'h10, 32'hCAFE7001, 0, 1, 9'd4, 32'hCAFE7001, 0));
    vt.push_back(mk(1, 2, 0, 32'h18, 32'hA5A5A5A5, 0, 1, 9'd6, 32'hA5A5A5A5, 0));
    vt.push_back(mk(0, 0, 0, 32'h17, 0, 7,  2, 9'd5, 32'hFFFFFF88, 0));
    vt.push_back(mk(0, 0, 1, 32'h17, 0, 8,  2, 9'd5, 32'h00000088, 0));
    vt.push_back(mk(0, 1, 1, 32'h14, 0, 9,  2, 9'd5, 32'h0000AABB, 0));
    vt.push_back(mk(0, 1, 0, 32'h16, 0, 10, 2, 9'd5, 32'hFFFF8899, 0));
    vt.push_back(mk(0, 2, 0, 32'h14, 0, 31, 2, 9'd5, 32'h8899AABB, 0));
    vt.push_back(mk(1, 0, 0, 32'h15, 32'hFFFFFF11, 0, 3, 9'd5, 32'h889911BB, 0));
    vt.push_back(mk(0, 2, 0, 32'h14, 0, 1,  2, 9'd5, 32'h889911BB, 0));
    vt.push_back(mk(1, 1, 0, 32'h16, 32'h12345678, 0, 3, 9'd5, 32'h567811BB, 0));
    vt.push_back(mk(0, 0, 0, 32'h14, 0, 2,  2, 9'd5, 32'hFFFFFFBB, 0));
    vt.push_back(mk(0, 2, 0, 32'h80000814, 0, 3, 2, 9'd5, 32'h567811BB, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
    vt.push_back(mk(0, 1, 0, 32'h13, 0, 11, 1, 9'd0, 32'h0, 1));
    vt.push_back(mk(0, 3, 0, 32'h14, 0, 12, 1, 9'd0, 32'h0, 1));
    vt.push_back(mk(0, 2, 0, 32'h17, 0, 13, 1, 9'd0, 32'h0, 1));
`else
    vt.push_back(mk(0, 1, 0, 32'h13, 0, 11, 2, 9'd4, 32'hFFFFCAFE, 0));
    vt.push_back(mk(0, 3, 0, 32'h14, 0, 12, 2, 9'd5, 32'h567811BB, 0));
    vt.push_back(mk(0, 2, 0, 32'h17, 0, 13, 2, 9'd5, 32'h567811BB, 0));
`endif
    vt.push_back(mk(0, 0, 1, 32'h10, 0, 14, 2, 9'd4, 32'h00000001, 0));
    vt.push_back(mk(1, 0, 0, 32'h13, 32'h00000042, 0, 3, 9'd4, 32'h42FE7001, 0));
    vt.push_back(mk(0, 2, 0, 32'h10, 0, 15, 2, 9'd4, 32'h42FE7001, 0));
    vt.push_back(mk(0, 1, 1, 32'h12, 0, 16, 2, 9'd4, 32'h000042FE, 0));

    for (int i = 0; i < vt.size(); i++) do_req(vt[i], i);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h14; req_rd = 5'd4;
    req_valid = 1'b1;
    r1 = -1; r2 = -1; nrsp = 0; d1 = '0; d2 = '0; rd1 = '0; rd2 = '0; rdy = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 3) rdy[c-1] = req_ready;
      if (c == 1) begin req_size = 2'd0; req_rd = 5'd5; end
      if (c == 4) req_valid = 1'b0;
      if (rsp_valid) begin
        if (nrsp == 0) begin r1 = c; d1 = rsp_data; rd1 = rsp_rd; end
        else begin r2 = c; d2 = rsp_data; rd2 = rsp_rd; end
        nrsp++;
      end
    end
    chk("b2b ready_busy_idle", {29'd0, rdy}, 32'b100);
    chk("b2b rsp_count", nrsp, 2);
    chk("b2b first_cycle", r1, 2);
    chk("b2b second_cycle", r2, r1 + 3);
    chk("b2b first_data", d1, 32'h567811BB);
    chk("b2b second_data", d2, 32'hFFFFFFBB);
    chk("b2b first_rd", {27'd0, rd1}, 32'd4);
    chk("b2b second_rd", {27'd0, rd2}, 32'd5);
    $display("txn b2b first_cycle=%0d second_cycle=%0d data=%h/%h", r1, r2, d1, d2);

    // Reset asserted while the sub-word store sits in RMW_MRG
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_addr = 32'h18; req_wdata = 32'h55; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mrg rmw_rd", {31'd0, rd}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_mrg outputs", {26'd0, req_ready, rsp_valid, rsp_load, rsp_err, rd, wr}, 32'd0);
    chk("rst_mrg addr", {23'd0, addr}, 32'd0);
    chk("rst_mrg rsp_data", rsp_data, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst_mrg hold%0d", c), {29'd0, req_ready, wr, rd}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 chk("rst_mrg ready_after", {31'd0, req_ready}, 32'd1);
    $display("txn reset_during_rmw released");
    v = mk(0, 2, 0, 32'h18, 0, 6, 2, 9'd6, 32'hA5A5A5A5, 0);
    do_req(v, 99);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller between the pipeline's MEM stage and the 512-word synchronous data RAM.
- Accepts one load or store per request via a valid/ready handshake and drives the RAM through the `wr`/`rd`/`addr`/`wr_data`/`rd_data` interface.
- Performs byte/halfword lane alignment, sign/zero extension and read-modify-write for sub-word stores.
- Returns load data, with its destination register number, to the writeback stage.

Parameters:
- ADDR_W, 9: RAM word-address width; word address = req_addr[ADDR_W+1:2].
- DATA_W, 32: data width; fixed at 32 for RV32.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 reserved.
- req_unsigned  in  1  zero-extend loads (LBU/LHU).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  load destination register.
- rsp_valid  out  1  one-cycle pulse: request completed.
- rsp_load  out  1  completed request was a load (writeback enable).
- rsp_data  out  32  extended load data; 0 for stores.
- rsp_rd  out  5  echoed req_rd for loads; 0 for stores.
- rsp_err  out  1  misaligned/reserved access.
- wr  out  1  RAM write strobe.
- rd  out  1  RAM read strobe; data is valid on rd_data the following cycle.
- addr  out  ADDR_W  RAM word address.
- wr_data  out  32  RAM write data.
- rd_data  in  32  RAM read data.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - All outputs 0 except req_ready, which is 1 once reset is released.
  - Any in-flight request is dropped with no response and no RAM write.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on a rising edge with req_valid & req_ready.
  - All request fields are registered at acceptance; inputs are ignored while busy.
- States: IDLE, WR, RD, RESP, RMW_RD, RMW_MRG, RMW_WR, ERR.
- Word store: IDLE -> WR.
  - In WR: wr=1, addr, wr_data=req_wdata, rsp_valid=1.
  - Then -> IDLE.
  - Latency: 1 cycle after acceptance.
- Load: IDLE -> RD -> RESP -> IDLE.
  - In RD: rd=1.
  - In RESP: rd_data is lane-extracted and sign/zero-extended, then output with rsp_valid=1, rsp_load=1, rsp_rd.
  - Latency: 2 cycles after acceptance.
- Sub-word store: IDLE -> RMW_RD -> RMW_MRG -> RMW_WR -> IDLE.
  - In RMW_RD: rd=1.
  - In RMW_MRG: rd_data is merged with the store lanes into a register.
  - In RMW_WR: wr=1 with the merged data, rsp_valid=1.
  - Latency: 3 cycles after acceptance.
- Lanes (little-endian):
  - Byte lane = addr[1:0].
  - Half lane = addr[1]: 0 selects bits [15:0], 1 selects bits [31:16].
- Strobe rules:
  - rd and wr are never high in the same cycle.
  - wr, rd and addr are 0 outside their active states.
- Response rules:
  - rsp_valid is high for exactly one cycle per accepted request.
  - rsp_* fields are 0 whenever rsp_valid=0.
- Address bits above ADDR_W+1 are ignored, so accesses wrap within the RAM.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, a word access with addr[1:0]!=0, or req_size=3 goes IDLE -> ERR.
  - No RAM access is made.
  - In ERR: rsp_valid=1, rsp_err=1, rsp_data=0, rsp_load=0. Then -> IDLE.
  - Latency: 1 cycle.
- Undefined:
  - rsp_err is tied to 0.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - req_size=3 is treated as a word access.

Decomposition:
- dmem_pkg holds:
  - size enum SZ_B/SZ_H/SZ_W/SZ_RSV;
  - state enum;
  - function load_extract(word, off, size, uns);
  - function store_merge(old, new, off, size).
- One sub-module, dmem_lane_align: combinational extract and merge, instantiated once in dmem_ctrl.

Test Plan:
1. SW addr 0x14, data 0xDEADBEEF, accepted at cycle T -> T+1: wr=1, addr=5, wr_data=0xDEADBEEF, rsp_valid=1, rsp_load=0.
2. mem[5]=0x8899AABB:
   - LB addr 0x17, rd=7 -> T+1 rd=1 addr=5; T+2 rsp_data=0xFFFFFF88, rsp_rd=7.
   - LBU -> rsp_data=0x00000088.
   - LHU addr 0x14 -> rsp_data=0x0000AABB.
3. SB addr 0x15, data 0x11, mem[5]=0x8899AABB -> T+1 rd=1; T+3 wr=1, wr_data=0x889911BB, rsp_valid=1.
4. LH addr 0x13:
   - With macro -> T+1 rsp_err=1, rd never asserted.
   - Without macro -> reads addr=4, upper half.
5. reset driven low during RMW_MRG -> wr never asserts, all outputs 0 immediately; req_ready=1 the cycle after release.
6. req_valid held high with two loads back-to-back -> req_ready low in RD/RESP; second load accepted on return to IDLE; its rsp_valid appears 3 cycles after the first.
